// File: rtl/spi_master_gen.sv
// spi_master_gen: SPI master with TX FIFO, all four modes, bit order, multi-CS and D/C
module spi_master_gen #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W = 16,
  localparam int CS_W = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div_factor,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_dc,
  input  logic [CS_W-1:0]   tx_cs_sel,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] sce_n,
  output logic              dc,
  output logic              lcd_rst_n
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = CS_W + 1 + DATA_W;
  localparam int EW = $clog2(2 * DATA_W);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0] fill_q, fill_d;
  logic [DIV_W-1:0] div_q, div_d, tmr_q, tmr_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [CS_W-1:0] sel_q, sel_d, head_sel;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d, drv_src, rx_nx;
  logic [NUM_CS-1:0] sce_n_q, sce_n_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, dc_q, dc_d, rx_valid_q, rx_valid_d, rst_n_q;
  logic push, pop, tick, last, lead, drive, sample, e_cpha, e_lsb;
  assign tx_ready = fill_q != (PTR_W + 1)'(FIFO_DEPTH);
  assign busy = state_q != IDLE || fill_q != '0;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign sce_n = sce_n_q;
  assign dc = dc_q;
  assign lcd_rst_n = rst_n_q;
  always_comb begin
    head_sel = mem_q[rd_q][ENT_W-1 -: CS_W];
    push = tx_valid && tx_ready;
    tick = state_q != IDLE && tmr_q == (div_q == '0 ? '0 : div_q - DIV_W'(1));
    lead = !edge_q[0];
    last = state_q == SHIFT && tick && edge_q == EW'(2 * DATA_W - 1);
    pop = fill_q != '0 && (state_q == IDLE || (last && head_sel == sel_q));
    e_cpha = state_q == IDLE ? cpha : cpha_q;
    e_lsb = state_q == IDLE ? lsb_first : lsb_q;
    drive = pop ? !e_cpha : state_q == SHIFT && tick && !last && lead == cpha_q;
    sample = state_q == SHIFT && tick && lead != cpha_q;
    drv_src = pop ? mem_q[rd_q][DATA_W-1:0] : tx_q;
    rx_nx = !sample ? rx_q : lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
    state_d = pop ? LOAD : state_q == LOAD && tick ? SHIFT : last ? GAP :
              state_q == GAP && tick ? IDLE : state_q;
    wr_d = wr_q + PTR_W'(push);
    rd_d = rd_q + PTR_W'(pop);
    fill_d = fill_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    tmr_d = state_q == IDLE || tick ? '0 : tmr_q + DIV_W'(1);
    edge_d = state_q != SHIFT ? '0 : edge_q + EW'(tick);
    cpol_d = state_q == IDLE ? cpol : cpol_q;
    cpha_d = state_q == IDLE ? cpha : cpha_q;
    lsb_d = state_q == IDLE ? lsb_first : lsb_q;
    div_d = state_q == IDLE ? div_factor : div_q;
    sel_d = pop ? head_sel : sel_q;
    dc_d = pop ? mem_q[rd_q][DATA_W] : dc_q;
    sce_n_d = pop ? ~(NUM_CS'(1) << head_sel) : last ? '1 : sce_n_q;
    mosi_d = drive ? (e_lsb ? drv_src[0] : drv_src[DATA_W-1]) : mosi_q;
    tx_d = drive ? (e_lsb ? drv_src >> 1 : drv_src << 1) : drv_src;
    sclk_d = state_q == IDLE ? cpol : last ? cpol_q : state_q == SHIFT && tick ? !sclk_q : sclk_q;
    rx_d = rx_nx;
    rx_data_d = last ? rx_nx : rx_data_q;
    rx_valid_d = last;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {tx_cs_sel, tx_dc, tx_data};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
      div_q <= '0;
      tmr_q <= '0;
      edge_q <= '0;
      sel_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rx_data_q <= '0;
      sce_n_q <= '1;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      dc_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      fill_q <= fill_d;
      div_q <= div_d;
      tmr_q <= tmr_d;
      edge_q <= edge_d;
      sel_q <= sel_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rx_data_q <= rx_data_d;
      sce_n_q <= sce_n_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      lsb_q <= lsb_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      dc_q <= dc_d;
      rx_valid_q <= rx_valid_d;
      rst_n_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: directed self-checking bench for spi_master_gen
module tb_spi_master_gen;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] div_factor = 16'd2;
  logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_dc = 1'b0, tx_cs_sel = 1'b0, tx_valid = 1'b0;
  logic tx_ready, rx_valid, busy, sclk, mosi, miso, dc, lcd_rst_n;
  logic [7:0] rx_data;
  logic [1:0] sce_n;
  logic loop = 1'b1, s_miso = 1'b0, sclk_p = 1'b0;
  logic [1:0] sce_p = 2'b11;
  logic [7:0] s_word = 8'h96, s_out = 8'h00, s_rx = 8'h00, mosi_seq = 8'h00;
  logic [7:0] rxq [$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int rises = 0, edges = 0, low0 = 0, low1 = 0, fall0 = 0, fall1 = 0, overlap = 0, bad_sw = 0, nrx = 0;
  assign miso = loop ? mosi : s_miso;
  always #5 clk = ~clk;
  spi_master_gen #(.DATA_W(8), .NUM_CS(2), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .div_factor(div_factor), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .tx_data(tx_data), .tx_dc(tx_dc), .tx_cs_sel(tx_cs_sel),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .sce_n(sce_n), .dc(dc),
    .lcd_rst_n(lcd_rst_n)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic ed, ld;
    ed = sclk != sclk_p;
    ld = ed && sclk != cpol;
    rises += int'(sclk && !sclk_p);
    edges += int'(ed);
    low0 += int'(!sce_n[0]);
    low1 += int'(!sce_n[1]);
    fall0 += int'(!sce_n[0] && sce_p[0]);
    fall1 += int'(!sce_n[1] && sce_p[1]);
    overlap += int'(sce_n == 2'b00);
    bad_sw += int'(!sce_n[1] && sce_p[1] && !sce_p[0]);
    if (rx_valid) begin
      nrx++;
      rxq.push_back(rx_data);
    end
    if (!sce_n[0] && sce_p[0]) begin
      s_out = s_word;
      if (!cpha) begin
        s_miso = lsb_first ? s_out[0] : s_out[7];
        s_out = lsb_first ? s_out >> 1 : s_out << 1;
      end
    end else if (ed && (!(&sce_n) || !(&sce_p))) begin
      if (ld != cpha) begin
        s_rx = lsb_first ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
        mosi_seq = {mosi_seq[6:0], mosi};
      end else begin
        s_miso = lsb_first ? s_out[0] : s_out[7];
        s_out = lsb_first ? s_out >> 1 : s_out << 1;
      end
    end
    sclk_p = sclk;
    sce_p = sce_n;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [7:0] rxat(input int i);
    return i < rxq.size() ? rxq[i] : 8'hxx;
  endfunction
  task automatic push(input logic [7:0] d, input logic c, input logic s);
    tx_data = d;
    tx_dc = c;
    tx_cs_sel = s;
    tx_valid = 1'b1;
    for (int i = 0; i < 5000 && !tx_ready; i++) @(negedge clk);
    chk("push_ready", tx_ready, 1);
    @(negedge clk);
  endtask
  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy; i++) @(negedge clk);
    chk("idle", busy, 0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end
  initial begin
    int r0, l0, l1, f0, f1, k0, e0, t0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_sce_n", sce_n, 2'b11);
    chk("rst_dc", dc, 0);
    chk("rst_lcd", lcd_rst_n, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("lcd_release", lcd_rst_n, 1);
    r0 = rises; l0 = low0; k0 = nrx;
    push(8'hA5, 1'b1, 1'b0);
    tx_valid = 1'b0;
    wait_idle(2000);
    chk("m0_rises", rises - r0, 8);
    chk("m0_cs_len", low0 - l0, 34);
    chk("m0_rx_cnt", nrx - k0, 1);
    chk("m0_rx_pulse", rxat(k0), 8'hA5);
    chk("m0_rx_data", rx_data, 8'hA5);
    chk("m0_mosi", mosi_seq, 8'hA5);
    chk("m0_dc", dc, 1);
    chk("m0_sce_end", sce_n, 2'b11);
    loop = 1'b0;
    for (int m = 1; m <= 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      lsb_first = m[2];
      repeat (2) @(negedge clk);
      chk($sformatf("idle_cpol_m%0d", m), sclk, cpol);
      push(8'h3C, 1'b1, 1'b0);
      tx_valid = 1'b0;
      wait_idle(2000);
      chk($sformatf("slave_rx_m%0d", m), s_rx, 8'h3C);
      chk($sformatf("mosi_ord_m%0d", m), mosi_seq, 8'h3C);
      chk($sformatf("rx_m%0d", m), rx_data, 8'h96);
      chk($sformatf("end_cpol_m%0d", m), sclk, cpol);
    end
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loop = 1'b1;
    repeat (2) @(negedge clk);
    l0 = low0; l1 = low1; f0 = fall0; f1 = fall1; k0 = nrx;
    push(8'h21, 1'b0, 1'b0);
    push(8'h0C, 1'b1, 1'b0);
    push(8'h80, 1'b1, 1'b1);
    tx_valid = 1'b0;
    wait_idle(4000);
    chk("burst_rx_cnt", nrx - k0, 3);
    chk("burst_rx0", rxat(k0), 8'h21);
    chk("burst_rx1", rxat(k0 + 1), 8'h0C);
    chk("burst_rx2", rxat(k0 + 2), 8'h80);
    chk("burst_cs0_falls", fall0 - f0, 1);
    chk("burst_cs1_falls", fall1 - f1, 1);
    chk("burst_cs0_len", low0 - l0, 68);
    chk("burst_cs1_len", low1 - l1, 34);
    chk("burst_overlap", overlap, 0);
    chk("burst_gap", bad_sw, 0);
    chk("burst_dc", dc, 1);
    div_factor = 16'd100;
    k0 = nrx;
    for (int i = 1; i <= 5; i++) push(8'h11 * i[7:0], 1'b1, 1'b0);
    chk("fifo_full", tx_ready, 0);
    chk("fifo_busy", busy, 1);
    t0 = cyc;
    push(8'h66, 1'b1, 1'b0);
    tx_valid = 1'b0;
    chk("fifo_w6_wait", int'(cyc - t0 > 1000), 1);
    wait_idle(20000);
    chk("fifo_rx_cnt", nrx - k0, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("fifo_rx%0d", i), rxat(k0 + i), 8'h11 * (i[7:0] + 8'd1));
    for (int d = 0; d < 2; d++) begin
      div_factor = d[15:0];
      l0 = low0; k0 = nrx;
      push(8'h5A, 1'b0, 1'b0);
      tx_valid = 1'b0;
      wait_idle(500);
      chk($sformatf("div%0d_cs_len", d), low0 - l0, 17);
      chk($sformatf("div%0d_rx", d), rxat(k0), 8'h5A);
    end
    div_factor = 16'd0;
    push(8'hC3, 1'b1, 1'b0);
    push(8'h3C, 1'b1, 1'b0);
    tx_valid = 1'b0;
    e0 = edges;
    for (int i = 0; i < 200 && edges - e0 < 5; i++) @(negedge clk);
    chk("abort_edge5", edges - e0, 5);
    k0 = nrx;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_sce_n", sce_n, 2'b11);
    chk("abort_busy", busy, 0);
    chk("abort_tx_ready", tx_ready, 1);
    chk("abort_lcd", lcd_rst_n, 0);
    chk("abort_sclk", sclk, 0);
    chk("abort_rx_data", rx_data, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_lcd_rel", lcd_rst_n, 1);
    repeat (50) @(negedge clk);
    chk("abort_no_rx", nrx - k0, 0);
    chk("abort_flushed", busy, 0);
    chk("abort_cs_idle", sce_n, 2'b11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Parametrised SPI master for the display path (Nokia 5110 class slaves) and other SPI peripherals.
- Generalises the single-byte master with:
  - configurable word width, all four SPI modes and MSB/LSB-first order;
  - multiple chip selects and a per-word D/C flag;
  - a small TX FIFO with a valid/ready handshake, so bursts hold CS low between words.
- Sits between the display configuration/draw controllers and the board SPI pins.

Parameters:
- DATA_W, 8: bits per SPI word.
- NUM_CS, 1: number of active-low chip-select outputs.
- FIFO_DEPTH, 4: TX FIFO entries (power of two, at least 2).
- DIV_W, 16: width of the clock divider input.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- div_factor  in  DIV_W  system clocks per SCLK half-period; 0 is treated as 1.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsb_first  in  1  1: shift LSB first.
- tx_data  in  DATA_W  word to send.
- tx_dc  in  1  D/C level for this word (0 command, 1 data).
- tx_cs_sel  in  clog2(NUM_CS) or at least 1  target chip select index.
- tx_valid  in  1  push request.
- tx_ready  out  1  FIFO not full.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle pulse; rx_data is updated.
- busy  out  1  FIFO not empty or transfer in progress.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- sce_n  out  NUM_CS  active-low chip selects.
- dc  out  1  D/C pin.
- lcd_rst_n  out  1  peripheral reset pin.

Behaviour:

Reset values:
- sclk=0, mosi=0, sce_n all 1, dc=0, lcd_rst_n=0.
- rx_data=0, rx_valid=0, busy=0; FIFO empty, so tx_ready=1.

Reset timing:
- lcd_rst_n goes to 1 on the first clk edge after reset deasserts.
- Reset mid-transfer aborts immediately: CS high, FIFO flushed, no rx_valid.

TX FIFO:
- A push occurs when tx_valid && tx_ready; each entry stores {tx_cs_sel, tx_dc, tx_data}.
- A push while full is ignored.
- Push and pop in the same cycle are both allowed; the count is unchanged.

Half-period tick:
- Tick = divider counter reaches max(div_factor,1)-1; the counter then returns to 0.
- The counter runs only outside IDLE.

FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - sclk follows cpol.
  - If the FIFO is non-empty, pop the entry, latch cpol/cpha/lsb_first/div_factor for the transfer, and go to LOAD.
- LOAD (one half-period):
  - Drive sce_n[sel]=0 and dc=entry dc.
  - If cpha=0, drive mosi with the first bit.
  - On tick, go to SHIFT.
- SHIFT: exactly 2*DATA_W ticks. Each tick toggles sclk; odd ticks are leading edges, even ticks are trailing edges.
  - cpha=0: sample miso on leading edges; drive the next bit on trailing edges (except the last).
  - cpha=1: drive a bit on leading edges; sample on trailing edges.
  - On the final tick, sclk returns to the latched cpol and rx_data is loaded with the assembled word. Bits land in received order, so with lsb_first the first received bit is bit 0. rx_valid is high for that one cycle.
  - Then, if the FIFO is non-empty and the head's cs_sel equals the current sel: pop it and go to LOAD with CS held low (burst). dc may change in LOAD.
  - Otherwise go to GAP.
- GAP (one half-period):
  - All sce_n=1, sclk=cpol.
  - On tick, go to IDLE.
- Config changes (cpol/cpha/lsb_first/div_factor) take effect only at the next IDLE-to-LOAD transition.
- An out-of-range tx_cs_sel (at least NUM_CS) is sent with no CS asserted.
- busy = (state != IDLE) || FIFO non-empty.

Test Plan:
- Mode 0 single word: DATA_W=8, div=2, tx 0xA5 dc=1, miso looped to mosi.
  - mosi sequence 1,0,1,0,0,1,0,1; 8 rising edges, 4 clk per SCLK period.
  - rx_valid pulse with rx_data=0xA5; sce_n[0] low for exactly (1+16) half-periods; dc=1.
- Modes 1-3 and LSB-first: tx 0x3C, each cpol/cpha combination, slave model per mode.
  - Slave model receives 0x3C; sclk idles at cpol.
  - lsb_first=1 gives mosi order 0,0,1,1,1,1,0,0.
- Burst and CS switch: push 0x21(cs0,dc0), 0x0C(cs0,dc1), 0x80(cs1) back-to-back.
  - sce_n[0] stays low across the first two words; GAP before sce_n[1] asserts.
  - Three rx_valid pulses; busy falls after the final GAP.
- FIFO full: DEPTH=4, div=100, push 6 words with tx_valid held.
  - tx_ready drops once 4 entries are held while word 1 shifts; word 6 is pushed only after a pop.
  - All pushed words are sent in order.
- div_factor=0 and reset abort: div=0 behaves identically to div=1 (SCLK period = 2 clk).
  - Assert reset at the 5th SCLK edge: sce_n all 1, FIFO empty, no rx_valid, lcd_rst_n=0, then 1 on the first clk after release.
